// File: rtl/pdu_pkg.sv
// pdu_pkg: shared state, halt-reason codes and index-width helper for the run/stop controller
package pdu_pkg;
    typedef enum logic [1:0] {HALTED, RUN, STEP} state_t;

    localparam logic [1:0] REASON_RESET = 2'd0;
    localparam logic [1:0] REASON_USER  = 2'd1;
    localparam logic [1:0] REASON_BP    = 2'd2;
    localparam logic [1:0] REASON_STEP  = 2'd3;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pdu_run_ctrl_bp_match.sv
// bp_match: breakpoint slot registers with a lowest-index-first comparator array
module bp_match
    import pdu_pkg::*;
#(
    parameter int NUM_BP = 4,
    parameter int PC_W   = 32,
    parameter int IDX_W  = idx_w(NUM_BP)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [PC_W-1:0]  addr,
    input  logic             en,
    input  logic [PC_W-1:0]  pc,
    output logic             match_any,
    output logic [IDX_W-1:0] match_idx
);
    logic [PC_W-1:0]   addr_q [NUM_BP];
    logic [NUM_BP-1:0] en_q;
    logic [NUM_BP-1:0] hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q <= '0;
            for (int i = 0; i < NUM_BP; i++) addr_q[i] <= '0;
        end else if (we && int'(idx) < NUM_BP) begin
            addr_q[idx] <= addr;
            en_q[idx]   <= en;
        end
    end

    for (genvar g = 0; g < NUM_BP; g++) begin : g_cmp
        assign hit[g] = en_q[g] && (addr_q[g] == pc);
    end

    // Scan high to low so the lowest matching slot is the one that sticks
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (hit[i]) begin
                match_any = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/pdu_run_ctrl.sv
// pdu_run_ctrl: PDU run/step/halt controller with breakpoints and retired-instruction count
module pdu_run_ctrl
    import pdu_pkg::*;
#(
    parameter int NUM_BP = 4,
    parameter int PC_W   = 32,
    parameter int STEP_W = 16,
    parameter int CNT_W  = 32,
    localparam int IDX_W = idx_w(NUM_BP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_run,
    input  logic              cmd_step,
    input  logic [STEP_W-1:0] step_n,
    input  logic              cmd_halt,
    input  logic              bp_we,
    input  logic [IDX_W-1:0]  bp_idx,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic              bp_en,
    input  logic              commit_valid,
    input  logic [PC_W-1:0]   commit_pc,
    output logic              cpu_run,
    output logic              cpu_stop,
    output logic [1:0]        halt_reason,
    output logic              hit_valid,
    output logic [IDX_W-1:0]  hit_idx,
    output logic [CNT_W-1:0]  retired_cnt
);
    state_t             state, state_d;
    logic [STEP_W-1:0]  steps, steps_d;
    logic [1:0]         reason_d;
    logic               hv_d;
    logic [IDX_W-1:0]   hidx_d;
    logic               match_any;
    logic [IDX_W-1:0]   match_idx;
    logic               ret;
    logic               bp_hit;

    assign ret    = commit_valid & cpu_run;
    assign bp_hit = ret & match_any;

    bp_match #(.NUM_BP(NUM_BP), .PC_W(PC_W), .IDX_W(IDX_W)) u_bp (
        .clk       (clk),
        .rst       (rst),
        .we        (bp_we),
        .idx       (bp_idx),
        .addr      (bp_addr),
        .en        (bp_en),
        .pc        (commit_pc),
        .match_any (match_any),
        .match_idx (match_idx)
    );

    always_comb begin
        state_d  = state;
        steps_d  = steps;
        reason_d = halt_reason;
        hv_d     = hit_valid;
        hidx_d   = hit_idx;
        case (state)
            HALTED: begin
                if (cmd_step) begin
                    state_d = STEP;
                    steps_d = (step_n == '0) ? STEP_W'(1) : step_n;
                    hv_d    = 1'b0;
                end else if (cmd_run) begin
                    state_d = RUN;
                    hv_d    = 1'b0;
                end
            end
            default: begin
                if (state == STEP && ret) steps_d = steps - STEP_W'(1);
                if (cmd_halt) begin
                    state_d  = HALTED;
                    reason_d = REASON_USER;
                end else if (bp_hit) begin
                    state_d  = HALTED;
                    reason_d = REASON_BP;
                    hv_d     = 1'b1;
                    hidx_d   = match_idx;
                end else if (state == STEP && ret && steps == STEP_W'(1)) begin
                    state_d  = HALTED;
                    reason_d = REASON_STEP;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HALTED;
            steps       <= '0;
            cpu_run     <= 1'b0;
            cpu_stop    <= 1'b1;
            halt_reason <= REASON_RESET;
            hit_valid   <= 1'b0;
            hit_idx     <= '0;
            retired_cnt <= '0;
        end else begin
            state       <= state_d;
            steps       <= steps_d;
            cpu_run     <= state_d != HALTED;
            cpu_stop    <= state_d == HALTED;
            halt_reason <= reason_d;
            hit_valid   <= hv_d;
            hit_idx     <= hidx_d;
            retired_cnt <= retired_cnt + CNT_W'(ret);
        end
    end
endmodule

// File: tb/tb_pdu_run_ctrl.sv
// tb_pdu_run_ctrl: directed stimulus with a queued-expectation scoreboard for pdu_run_ctrl
module tb_pdu_run_ctrl;
    localparam int NB = 5;

    typedef struct packed {
        logic        run;
        logic [1:0]  reason;
        logic        hv;
        logic [2:0]  hidx;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        cmd_run = 0, cmd_step = 0, cmd_halt = 0;
    logic [15:0] step_n = 0;
    logic        bp_we = 0, bp_en = 0;
    logic [2:0]  bp_idx = 0;
    logic [31:0] bp_addr = 0;
    logic        commit_valid = 0;
    logic [31:0] commit_pc = 0;
    logic        cpu_run, cpu_stop, hit_valid;
    logic [1:0]  halt_reason;
    logic [2:0]  hit_idx;
    logic [31:0] retired_cnt;

    exp_t  q[$];
    string nq[$];
    exp_t  e;
    string n;
    int    tests = 0, fails = 0;

    pdu_run_ctrl #(.NUM_BP(NB), .PC_W(32), .STEP_W(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .cmd_run(cmd_run), .cmd_step(cmd_step), .step_n(step_n),
        .cmd_halt(cmd_halt), .bp_we(bp_we), .bp_idx(bp_idx), .bp_addr(bp_addr), .bp_en(bp_en),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .cpu_run(cpu_run), .cpu_stop(cpu_stop),
        .halt_reason(halt_reason), .hit_valid(hit_valid), .hit_idx(hit_idx), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            n = nq.pop_front();
            tests++;
            if (cpu_run !== e.run || cpu_stop !== ~e.run || halt_reason !== e.reason ||
                hit_valid !== e.hv || hit_idx !== e.hidx || retired_cnt !== e.cnt) begin
                fails++;
                $display("FAIL %s: got run=%0d stop=%0d reason=%0d hv=%0d idx=%0d cnt=%0d, want run=%0d stop=%0d reason=%0d hv=%0d idx=%0d cnt=%0d",
                         n, cpu_run, cpu_stop, halt_reason, hit_valid, hit_idx, retired_cnt,
                         e.run, ~e.run, e.reason, e.hv, e.hidx, e.cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic r, input logic [1:0] rs, input logic h,
                       input logic [2:0] i, input logic [31:0] c);
        q.push_back('{run: r, reason: rs, hv: h, hidx: i, cnt: c});
        nq.push_back(nm);
    endtask

    task automatic commit(input logic [31:0] pc);
        commit_valid = 1;
        commit_pc = pc;
        tick();
        commit_valid = 0;
    endtask

    task automatic run_cmd();
        cmd_run = 1;
        tick();
        cmd_run = 0;
    endtask

    task automatic halt_cmd();
        cmd_halt = 1;
        tick();
        cmd_halt = 0;
    endtask

    task automatic step_cmd(input logic [15:0] s);
        cmd_step = 1;
        step_n = s;
        tick();
        cmd_step = 0;
    endtask

    task automatic bp_write(input logic [2:0] i, input logic [31:0] a, input logic en);
        bp_we = 1;
        bp_idx = i;
        bp_addr = a;
        bp_en = en;
        tick();
        bp_we = 0;
    endtask

    initial begin
        tick();
        tick();
        rst = 0;
        chk("reset", 0, 0, 0, 0, 0);

        run_cmd();
        chk("run_start", 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) commit(32'h1000 + 32'(4 * i));
        chk("run_10", 1, 0, 0, 0, 10);
        halt_cmd();
        chk("user_halt", 0, 1, 0, 0, 10);

        bp_write(2, 32'h40, 1);
        run_cmd();
        for (int i = 0; i < 5; i++) commit(32'h30 + 32'(4 * i));
        chk("bp2_hit", 0, 2, 1, 2, 15);
        commit(32'h44);
        chk("halted_ignores_commit", 0, 2, 1, 2, 15);

        bp_write(1, 32'h100, 1);
        bp_write(3, 32'h100, 1);
        run_cmd();
        chk("resume_clears_hv", 1, 2, 0, 2, 15);
        commit(32'h100);
        chk("bp_lowest_idx", 0, 2, 1, 1, 16);
        run_cmd();
        commit(32'h104);
        commit(32'h108);
        chk("no_retrigger", 1, 2, 0, 1, 18);
        halt_cmd();
        chk("halt_again", 0, 1, 0, 1, 18);

        step_cmd(3);
        chk("step_start", 1, 1, 0, 1, 18);
        for (int i = 0; i < 5; i++) commit(32'h200 + 32'(4 * i));
        chk("step3_done", 0, 3, 0, 1, 21);
        cmd_run = 1;
        step_cmd(0);
        cmd_run = 0;
        for (int i = 0; i < 3; i++) commit(32'h300 + 32'(4 * i));
        chk("step0_as_1", 0, 3, 0, 1, 22);

        step_cmd(5);
        commit(32'h3c);
        cmd_halt = 1;
        commit(32'h40);
        cmd_halt = 0;
        chk("halt_beats_bp", 0, 1, 0, 1, 24);
        step_cmd(2);
        commit(32'h3c);
        commit(32'h40);
        chk("bp_beats_step", 0, 2, 1, 2, 26);

        bp_write(3'(NB), 32'h500, 1);
        run_cmd();
        commit(32'h500);
        commit(32'h504);
        chk("oob_write_ignored", 1, 2, 0, 2, 28);
        commit(32'h40);
        chk("slot2_kept", 0, 2, 1, 2, 29);

        run_cmd();
        for (int i = 0; i < 28; i++) commit(32'h2000 + 32'(4 * i));
        chk("cnt_57", 1, 2, 0, 2, 57);
        rst = 1;
        cmd_run = 1;
        commit_valid = 1;
        commit_pc = 32'h40;
        tick();
        rst = 0;
        cmd_run = 0;
        commit_valid = 0;
        chk("mid_run_reset", 0, 0, 0, 0, 0);
        run_cmd();
        commit(32'h40);
        commit(32'h100);
        chk("slots_cleared", 1, 0, 0, 0, 2);
        halt_cmd();
        chk("final_halt", 0, 1, 0, 0, 2);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pdu_run_ctrl.md
Name: pdu_run_ctrl

Overview:
- Parametrised run/stop controller between the PDU and the pipeline CPU.
- Successor to the single-breakpoint pdu_run/cpu_stop handshake.
- Adds NUM_BP independent breakpoints, N-instruction stepping, user halt, halt-reason reporting and a retired-instruction counter.
- Drives the CPU's advance enable and sits in the top level between the PDU and the CPU control bus.

Parameters:
- NUM_BP, 4, number of breakpoint slots (1..16).
- PC_W, 32, PC/breakpoint address width.
- STEP_W, 16, width of the step-count operand.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_run  in  1  single-cycle pulse: free-run
- cmd_step  in  1  single-cycle pulse: run step_n instructions
- step_n  in  STEP_W  step count, sampled with cmd_step
- cmd_halt  in  1  single-cycle pulse: user halt
- bp_we  in  1  breakpoint slot write strobe
- bp_idx  in  clog2(NUM_BP) (min 1)  slot index
- bp_addr  in  PC_W  breakpoint address
- bp_en  in  1  slot enable written with bp_addr
- commit_valid  in  1  CPU retires an instruction this cycle
- commit_pc  in  PC_W  PC of the retiring instruction
- cpu_run  out  1  CPU may advance (registered)
- cpu_stop  out  1  inverse of cpu_run (registered)
- halt_reason  out  2  0 reset, 1 user, 2 breakpoint, 3 step done
- hit_valid  out  1  last halt was a breakpoint hit
- hit_idx  out  clog2(NUM_BP)  lowest matching slot of that hit
- retired_cnt  out  CNT_W  instructions retired since reset

Behaviour:
- Reset values:
  - state HALTED; cpu_run=0, cpu_stop=1.
  - halt_reason=0, hit_valid=0, hit_idx=0, retired_cnt=0.
  - All slots disabled with address 0; step counter 0.
- States: HALTED, RUN, STEP. cpu_run=1 in RUN/STEP, 0 in HALTED. cpu_stop = ~cpu_run at all times.
- Retire event:
  - ret = commit_valid & cpu_run. commit_valid while cpu_run=0 is ignored entirely.
  - ret increments retired_cnt, which wraps at 2^CNT_W.
- Breakpoint match:
  - Slot i matches when its enable is set and its address equals commit_pc, on a ret cycle.
  - Halt is taken after the matching instruction retires.
  - Resuming therefore never re-triggers on the same instruction.
- HALTED:
  - cmd_run -> RUN.
  - cmd_step -> STEP; step counter loads step_n, with step_n=0 treated as 1.
  - cmd_halt is ignored.
  - Leaving HALTED clears hit_valid. halt_reason holds its value.
- RUN:
  - Breakpoint match -> HALTED, reason 2, hit_valid=1, hit_idx = lowest matching index.
  - cmd_halt -> HALTED, reason 1.
  - cmd_run and cmd_step are ignored.
- STEP:
  - Each ret decrements the step counter.
  - ret with counter==1 -> HALTED, reason 3.
  - Breakpoint match -> HALTED, reason 2; this takes priority over step-done on the same cycle.
  - cmd_halt -> HALTED, reason 1.
  - cmd_run and cmd_step are ignored.
- Simultaneous events in the same cycle:
  - Priority is cmd_halt > breakpoint > step-done.
  - In HALTED, cmd_run together with cmd_step: cmd_step wins.
  - The retire on a halting cycle is still counted.
- Timing: match or command at edge t -> cpu_run=0 visible after edge t+1 (one-cycle latency). The CPU may complete the retire presented in cycle t only.
- Breakpoint writes:
  - Accepted in any state; the new slot value takes effect for commits from the next cycle.
  - bp_idx >= NUM_BP: write ignored.
- rst mid-run forces the full reset state in the next cycle, regardless of commands.

Decomposition:
- Shared package pdu_pkg holds:
  - the state enum (HALTED/RUN/STEP);
  - the halt-reason codes (REASON_RESET/USER/BP/STEP);
  - the IDX_W = max(1, clog2(NUM_BP)) helper.
- Sub-module bp_match: slot register file plus comparator array and lowest-index priority encoder. Outputs are match_any and match_idx, purely combinational on commit_pc.

Test Plan:
- Reset, then cmd_run, then 10 cycles of commit_valid=1 -> cpu_run=1 one cycle after cmd_run; retired_cnt=10; halt_reason stays 0.
- Slot 2 = 0x0000_0040 enabled; run with commits of PCs 0x30, 0x34, ... -> halt after the 0x40 commit; cpu_run=0 next cycle; halt_reason=2, hit_valid=1, hit_idx=2.
- Slots 1 and 3 both = 0x100; commit 0x100 in RUN -> hit_idx=1; then cmd_run -> no re-halt at 0x100, and hit_valid clears.
- cmd_step with step_n=3 and continuous commits -> exactly 3 retires counted, then halt_reason=3. Repeat with step_n=0 -> exactly 1 retire.
- In STEP, cmd_halt in the same cycle as a breakpoint match -> halt_reason=1. Breakpoint on the final step -> halt_reason=2.
- rst asserted during RUN with retired_cnt=57 -> next cycle: HALTED, retired_cnt=0, all slots disabled, halt_reason=0. bp_we with bp_idx=NUM_BP leaves all slots unchanged.
